// File: rtl/add_sched32.sv
`default_nettype none
// ============================================================================
//  Module   : add_sched32
//  Brief    : Two-requester round-robin scheduler in front of a byte-serial
//             WIDTH-bit adder. One SLICE-bit add slice is reused for
//             WIDTH/SLICE cycles per operation. Each result is tagged with
//             the id of the requester that issued it.
//  Revision : 1.0  initial release
// ============================================================================
module add_sched32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             C00,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             C01,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] SUM,
  output logic             Overflow
);

  localparam int NBYTE = WIDTH / SLICE;
  localparam int CW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(NBYTE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;
  logic             last_grant_q, last_grant_d;

  logic             grant_any;
  logic             grant_id;
  logic [SLICE-1:0] a_byte;
  logic [SLICE-1:0] b_byte;
  logic [SLICE:0]   slice_res;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   begin grant_any = 1'b1; grant_id = 1'b0;          end
      2'b10:   begin grant_any = 1'b1; grant_id = 1'b1;          end
      2'b11:   begin grant_any = 1'b1; grant_id = ~last_grant_q; end
      default: begin grant_any = 1'b0; grant_id = 1'b0;          end
    endcase
    req_ready = 2'b00;
    if ((state_q == ST_IDLE) && grant_any) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  // Shared add slice: selects operand byte cnt and adds it with the running carry.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_byte = a_q[i*SLICE +: SLICE];
        b_byte = b_q[i*SLICE +: SLICE];
      end
    end
    slice_res  = {1'b0, a_byte} + {1'b0, b_byte} + {{SLICE{1'b0}}, carry_q};
    slice_sum  = slice_res[SLICE-1:0];
    slice_cout = slice_res[SLICE];
  end

  // Next-state logic for the IDLE -> BUSY -> DONE operation sequence.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    ovf_d        = ovf_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          a_d          = grant_id ? A1 : A0;
          b_d          = grant_id ? B1 : B0;
          carry_d      = grant_id ? C01 : C00;
          res_id_d     = grant_id;
          last_grant_d = grant_id;
          cnt_d        = '0;
          sum_d        = '0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < NBYTE; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*SLICE +: SLICE] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (cnt_q == C_CNT_LAST) begin
          // Final slice: its carry-out is the unsigned carry of the full sum.
          ovf_d       = slice_cout;
          cnt_d       = '0;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Result registers are untouched here, so they stay stable until taken.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      ovf_q        <= ovf_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign SUM       = sum_q;
  assign Overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add_sched32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sched32
//  Brief    : Self-checking bench for add_sched32 with a transaction-level
//             reference model (full-width addition plus round-robin state).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sched32;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NBYTE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             C00, C01;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] SUM;
  logic             Overflow;

  int   checks = 0;
  int   errors = 0;
  logic model_last = 1'b1;

  add_sched32 #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A0        (A0),
    .B0        (B0),
    .C00       (C00),
    .A1        (A1),
    .B1        (B1),
    .C01       (C01),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .SUM       (SUM),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       rnd_word = '1;
      1:       rnd_word = '0;
      default: rnd_word = $urandom;
    endcase
  endfunction

  task automatic randomize_ops();
    A0  = rnd_word();
    B0  = rnd_word();
    C00 = 1'($urandom_range(0, 1));
    A1  = rnd_word();
    B1  = rnd_word();
    C01 = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the DUT idle. Drives req_valid, checks the grant,
  // then follows the operation to its result and handshake. 'hold' is the
  // number of DONE cycles with res_ready low; 'scramble' changes operands mid-flight.
  task automatic issue(input logic [1:0] v, input int hold, input bit scramble);
    logic         g;
    logic [WIDTH:0] exp;
    req_valid = v;
    res_ready = (hold == 0);
    #1;
    if (v == 2'b01)      g = 1'b0;
    else if (v == 2'b10) g = 1'b1;
    else                 g = ~model_last;
    if (g) exp = {1'b0, A1} + {1'b0, B1} + {{WIDTH{1'b0}}, C01};
    else   exp = {1'b0, A0} + {1'b0, B0} + {{WIDTH{1'b0}}, C00};
    check("grant", req_ready, g ? 2'b10 : 2'b01);
    model_last = g;
    @(posedge clk);
    for (int k = 0; k < NBYTE; k++) begin
      @(negedge clk);
      if (scramble) randomize_ops();
      #1;
      check("busy_res_valid", res_valid, 1'b0);
      check("busy_req_ready", req_ready, 2'b00);
      @(posedge clk);
    end
    @(negedge clk);
    check("done_res_valid", res_valid, 1'b1);
    check("sum", SUM, exp[WIDTH-1:0]);
    check("overflow", Overflow, exp[WIDTH]);
    check("res_id", res_id, g);
    check("done_req_ready", req_ready, 2'b00);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_sum", SUM, exp[WIDTH-1:0]);
      check("hold_overflow", Overflow, exp[WIDTH]);
      check("hold_req_ready", req_ready, 2'b00);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_hs_res_valid", res_valid, 1'b0);
    check("after_hs_idle_ready", (req_ready != 2'b00), (v != 2'b00));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    A0 = '0; B0 = '0; C00 = 1'b0;
    A1 = '0; B1 = '0; C01 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_res_id", res_id, 1'b0);
    check("rst_sum", SUM, 32'h0);
    check("rst_overflow", Overflow, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Full carry ripple out of the top byte.
    A0 = 32'hFFFF_FFFF; B0 = 32'h0000_0001; C00 = 1'b0;
    issue(2'b01, 0, 1'b0);

    // Carry from byte 1 into byte 2 on requester 1 with carry-in set.
    A1 = 32'h0000_FF00; B1 = 32'h0000_0100; C01 = 1'b1;
    issue(2'b10, 0, 1'b0);

    // Continuous contention: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      issue(2'b11, 0, 1'b0);
    end

    // Result held while the consumer stalls.
    A0 = 32'h1234_5678; B0 = 32'h1111_1111; C00 = 1'b0;
    issue(2'b01, 3, 1'b0);

    // Operand changes after accept must not affect the result.
    randomize_ops();
    issue(2'b01, 0, 1'b1);
    randomize_ops();
    issue(2'b10, 1, 1'b1);

    // Reset in the second BUSY cycle discards the operation.
    req_valid = 2'b00;
    @(negedge clk);
    A1 = 32'hDEAD_BEEF; B1 = 32'h0101_0101; C01 = 1'b1;
    req_valid = 2'b10;
    res_ready = 1'b1;
    #1;
    check("rst_test_grant", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_sum", SUM, 32'h0);
    check("mid_rst_overflow", Overflow, 1'b0);
    check("mid_rst_res_id", res_id, 1'b0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    model_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("discarded_res_valid", res_valid, 1'b0);
    end
    randomize_ops();
    issue(2'b11, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] v;
      randomize_ops();
      v = 2'($urandom_range(1, 3));
      issue(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
